// File: rtl/barrier_pkg.sv
// Shared types and helpers for the barrier scheduler: FSM state encoding,
// lane constants and the lane-selection LFSR helpers.
package barrier_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        TRAVEL,
        JUDGE,
        RETIRE,
        OVER
    } state_t;

    localparam logic [1:0] LANE_L = 2'd0;
    localparam logic [1:0] LANE_M = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    // Galois taps for x^8+x^6+x^5+x^4+1, right-shifting form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Low two LFSR bits pick the lane; the out-of-range code folds to mid
    function automatic logic [1:0] lane_pick(input logic [7:0] lfsr);
        return (lfsr[1:0] > LANE_R) ? LANE_M : lfsr[1:0];
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr);
        return lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    endfunction

    // Player lane code 3 is treated as mid
    function automatic logic [1:0] player_lane(input logic [1:0] lane);
        return (lane == 2'd3) ? LANE_M : ((lane == LANE_L) ? LANE_L : lane);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the raw vertical sync into the clock domain and turns each rising
// edge into a single-cycle frame tick, three clocks after the raw edge.
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_v_sync,
    output logic o_tick
);

    // sync[0..1] form the synchronizer, sync[2] holds the previous value
    logic [2:0] sync;

    // Synchronize, then register the rising-edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync   <= 3'b000;
            o_tick <= 1'b0;
        end else begin
            sync   <= {sync[1:0], i_v_sync};
            o_tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/barrier_scheduler.sv
// Runner-game barrier sequencer: launches one barrier per wave on an
// LFSR-chosen lane, judges the collision when the sprite reports
// in-position, and keeps score, lives and the game-over flag.
module barrier_scheduler
    import barrier_pkg::*;
#(
    parameter int         GAP_FRAMES     = 30,
    parameter int         TRAVEL_TIMEOUT = 40,
    parameter int         RETIRE_FRAMES  = 8,
    parameter int         LIVES          = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    parameter int         SCORE_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_v_sync,
    input  logic               i_start,
    input  logic [1:0]         i_player_lane,
    input  logic               i_player_jump,
    input  logic [2:0]         i_in_position,
    output logic [2:0]         o_active,
    output logic [1:0]         o_lane,
    output logic               o_hit,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         o_lives,
    output logic               o_game_over,
    output logic               o_timeout
);

    // An all-zero seed would lock the LFSR up
    localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] GAP_CNT   = 8'(GAP_FRAMES);
    localparam logic [7:0] TO_CNT    = 8'(TRAVEL_TIMEOUT);
    localparam logic [7:0] RET_CNT   = 8'(RETIRE_FRAMES);
    localparam logic [1:0] LIVES_INI = 2'(LIVES);

    logic       frame_tick;
    state_t     state;
    logic [7:0] frame_cnt;
    logic [7:0] lfsr;
    logic [1:0] next_lane;
    logic [3:0] in_pos_ext;
    logic       hit_now;

    frame_tick_gen u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_v_sync (i_v_sync),
        .o_tick   (frame_tick)
    );

    assign next_lane  = lane_pick(lfsr);
    // Pad so the lane index is always in range; only the current lane counts
    assign in_pos_ext = {1'b0, i_in_position};
    assign hit_now    = (player_lane(i_player_lane) == o_lane) && !i_player_jump;

    // Wave sequencer with registered outputs; i_start overrides everything
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            frame_cnt   <= 8'd0;
            lfsr        <= SEED;
            o_active    <= 3'b000;
            o_lane      <= LANE_M;
            o_hit       <= 1'b0;
            o_score     <= '0;
            o_lives     <= LIVES_INI;
            o_game_over <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_hit <= 1'b0;
            // Everything is frozen once the game is over
            if (frame_tick && state != OVER) begin
                lfsr <= lfsr_next(lfsr);
                if (frame_cnt != 8'hFF)
                    frame_cnt <= frame_cnt + 8'd1;
            end
            if (i_start) begin
                state       <= GAP;
                frame_cnt   <= 8'd0;
                o_active    <= 3'b000;
                o_score     <= '0;
                o_lives     <= LIVES_INI;
                o_game_over <= 1'b0;
                o_timeout   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    GAP: begin
                        if (frame_tick && frame_cnt == GAP_CNT) begin
                            state     <= TRAVEL;
                            frame_cnt <= 8'd0;
                            o_lane    <= next_lane;
                            o_active  <= 3'b001 << next_lane;
                        end
                    end
                    TRAVEL: begin
                        // in_position beats a coincident timeout tick
                        if (in_pos_ext[o_lane]) begin
                            state     <= JUDGE;
                            frame_cnt <= 8'd0;
                        end else if (frame_tick && frame_cnt == TO_CNT) begin
                            state     <= RETIRE;
                            frame_cnt <= 8'd0;
                            o_timeout <= 1'b1;
                        end
                    end
                    JUDGE: begin
                        frame_cnt <= 8'd0;
                        if (hit_now) begin
                            o_hit   <= 1'b1;
                            o_lives <= o_lives - 2'd1;
                            if (o_lives == 2'd1) begin
                                state       <= OVER;
                                o_active    <= 3'b000;
                                o_game_over <= 1'b1;
                            end else begin
                                state <= RETIRE;
                            end
                        end else begin
                            state <= RETIRE;
                            if (o_score != '1)
                                o_score <= o_score + SCORE_W'(1);
                        end
                    end
                    RETIRE: begin
                        if (frame_tick && frame_cnt == RET_CNT) begin
                            state     <= GAP;
                            frame_cnt <= 8'd0;
                            o_active  <= 3'b000;
                        end
                    end
                    OVER: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barrier_scheduler.sv
// Randomized bench for barrier_scheduler against a game-rule reference model.
module tb_barrier_scheduler;

    localparam int P_IDLE = 0, P_GAP = 1, P_TRAVEL = 2, P_JUDGE = 3, P_RETIRE = 4, P_OVER = 5;

    logic        clk;
    logic        rst_n;
    logic        vs;
    logic        start;
    logic [1:0]  pl;
    logic        jump;
    logic [2:0]  inpos;
    logic [2:0]  o_active;
    logic [1:0]  o_lane;
    logic        o_hit;
    logic [15:0] o_score;
    logic [1:0]  o_lives;
    logic        o_game_over;
    logic        o_timeout;

    barrier_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_v_sync      (vs),
        .i_start       (start),
        .i_player_lane (pl),
        .i_player_jump (jump),
        .i_in_position (inpos),
        .o_active      (o_active),
        .o_lane        (o_lane),
        .o_hit         (o_hit),
        .o_score       (o_score),
        .o_lives       (o_lives),
        .o_game_over   (o_game_over),
        .o_timeout     (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run, n_fail, cyc;
    int vs_cnt, period, rst_hold;
    bit noin, did_si, did_rst;

    // reference model: game phase, ticks seen in phase, game counters
    int         m_ph, m_cnt, m_lane, m_score, m_lives;
    bit         m_hit, m_to;
    logic [7:0] m_lfsr;
    logic [4:0] h;   // sampled v_sync history, h[0] newest

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_ph = P_IDLE; m_cnt = 0; m_lane = 1; m_score = 0; m_lives = 3;
        m_hit = 0; m_to = 0; m_lfsr = 8'hA5; h = '0;
    endtask

    task automatic m_step();
        logic [7:0] old;
        bit tick;
        int eff;
        h = {h[3:0], vs};
        tick = h[3] & ~h[4];   // tick acts three clocks after the raw rise
        m_hit = 0;
        old = m_lfsr;
        if (tick && m_ph != P_OVER)
            m_lfsr = old[0] ? ((old >> 1) ^ 8'hB8) : (old >> 1);
        if (start) begin
            m_ph = P_GAP; m_cnt = 0; m_score = 0; m_lives = 3; m_to = 0;
        end else begin
            case (m_ph)
                P_GAP: if (tick) begin
                    if (m_cnt == 30) begin
                        m_lane = (old[1:0] == 2'd3) ? 1 : int'(old[1:0]);
                        m_ph = P_TRAVEL; m_cnt = 0;
                    end else m_cnt++;
                end
                P_TRAVEL: begin
                    if (inpos[m_lane]) begin
                        m_ph = P_JUDGE; m_cnt = 0;
                    end else if (tick) begin
                        if (m_cnt == 40) begin m_to = 1; m_ph = P_RETIRE; m_cnt = 0; end
                        else m_cnt++;
                    end
                end
                P_JUDGE: begin
                    eff = (pl == 2'd3) ? 1 : int'(pl);
                    m_cnt = 0;
                    if (eff == m_lane && !jump) begin
                        m_hit = 1; m_lives--;
                        m_ph = (m_lives == 0) ? P_OVER : P_RETIRE;
                    end else begin
                        if (m_score < 65535) m_score++;
                        m_ph = P_RETIRE;
                    end
                end
                P_RETIRE: if (tick) begin
                    if (m_cnt == 8) begin m_ph = P_GAP; m_cnt = 0; end
                    else m_cnt++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_all();
        logic [2:0] ea;
        ea = (m_ph == P_TRAVEL || m_ph == P_JUDGE || m_ph == P_RETIRE) ? 3'(1 << m_lane) : 3'd0;
        chk("active",    32'(o_active),    32'(ea));
        chk("lane",      32'(o_lane),      32'(m_lane));
        chk("hit",       32'(o_hit),       32'(m_hit));
        chk("score",     32'(o_score),     32'(m_score));
        chk("lives",     32'(o_lives),     32'(m_lives));
        chk("game_over", 32'(o_game_over), 32'(m_ph == P_OVER));
        chk("timeout",   32'(o_timeout),   32'(m_to));
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_active"},  32'(o_active),    32'd0);
        chk({tag, "_lane"},    32'(o_lane),      32'd1);
        chk({tag, "_hit"},     32'(o_hit),       32'd0);
        chk({tag, "_score"},   32'(o_score),     32'd0);
        chk({tag, "_lives"},   32'(o_lives),     32'd3);
        chk({tag, "_over"},    32'(o_game_over), 32'd0);
        chk({tag, "_timeout"}, 32'(o_timeout),   32'd0);
    endtask

    task automatic drive();
        start = 1'b0;
        pl    = 2'($urandom_range(0, 3));
        jump  = ($urandom_range(0, 3) == 0);
        inpos = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
        vs = (vs_cnt < period / 2);
        vs_cnt++;
        if (vs_cnt >= period) begin
            vs_cnt = 0;
            if (cyc > 6000) period = $urandom_range(6, 30);
        end
        case (m_ph)
            P_IDLE:   start = ($urandom_range(0, 3) == 0);
            P_GAP: begin
                noin  = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 2999) == 0);
            end
            P_TRAVEL: begin
                inpos[m_lane] = 1'b0;
                if (!did_si && cyc > 8000) begin
                    did_si = 1; start = 1'b1; inpos[m_lane] = 1'b1;
                end else if (!noin && $urandom_range(0, 39) == 0) begin
                    inpos[m_lane] = 1'b1;
                end
            end
            P_JUDGE:  start = ($urandom_range(0, 7) == 0);
            P_RETIRE: start = ($urandom_range(0, 2999) == 0);
            default:  start = ($urandom_range(0, 19) == 0);
        endcase
    endtask

    initial begin
        n_run = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b1; start = 1'b0; pl = 2'd0; jump = 1'b0; inpos = 3'd0; vs = 1'b0;
        vs_cnt = 0; period = 100; rst_hold = 3; noin = 0; did_si = 0; did_rst = 0;
        m_reset();
        #1 rst_n = 1'b0;
        #1 chk_rst("rst");
        while (cyc < 40000 && n_fail < 50) begin
            @(negedge clk);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
            drive();
            @(posedge clk);
            if (!rst_n) m_reset();
            else m_step();
            #1 chk_all();
            // async reset mid-wave: outputs must drop before the next edge
            if (!did_rst && cyc > 25000 && m_ph == P_TRAVEL) begin
                did_rst = 1;
                #2 rst_n = 1'b0;
                #1 chk_rst("midrst");
                m_reset();
                rst_hold = 2;
            end
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/barrier_scheduler.md
Name: barrier_scheduler

Overview:
- Sequences the three lane barrier sprites (left/mid/right) of the runner game.
- Starts one barrier per wave on a pseudo-random lane and times its approach in frames.
- Judges player collision when the barrier reports in-position, and maintains score, lives and game-over state.
- Sits between the game top level (start/player inputs) and the barrier sprite instances (drives their active inputs, reads their in_position).

Parameters:
- GAP_FRAMES, 30, idle frames between retiring one barrier and launching the next.
- TRAVEL_TIMEOUT, 40, maximum frames to wait for in-position before abandoning the wave.
- RETIRE_FRAMES, 8, frames the barrier stays active after judging, before it is dropped.
- LIVES, 3, lives at game start.
- LFSR_SEED, 8'hA5, LFSR reset value; 8'h00 is forced to 8'h01.
- SCORE_W, 16, score counter width.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_v_sync, input, 1, raw vertical sync; asynchronous to i_clk.
- i_start, input, 1, one-cycle pulse that starts or restarts a game.
- i_player_lane, input, 2, 0=left, 1=mid, 2=right; 3 is treated as mid.
- i_player_jump, input, 1, player airborne; an airborne player cannot be hit.
- i_in_position, input, 3, per-lane in_position from the barrier sprites.
- o_active, output, 3, one-hot barrier enable per lane.
- o_lane, output, 2, lane of the current or last wave.
- o_hit, output, 1, one-cycle pulse on collision.
- o_score, output, SCORE_W, barriers cleared.
- o_lives, output, 2, lives remaining.
- o_game_over, output, 1, high while in state OVER.
- o_timeout, output, 1, sticky; cleared by i_start.

Behaviour:
- Reset (async, i_rst_n low), all outputs and counters:
  - state=IDLE, o_active=0, o_lane=1, o_score=0, o_lives=LIVES, o_hit=0, o_game_over=0, o_timeout=0.
  - LFSR=LFSR_SEED.
- Frame tick generation:
  - i_v_sync passes through a 2-FF synchronizer, then rising-edge detect.
  - frame_tick is a one-cycle pulse, 3 cycles after the raw edge.
  - All frame counts are in frame_tick units.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances on every frame_tick in every state except OVER.
  - Lane pick = lfsr[1:0]; value 3 maps to 1.
- frame_cnt:
  - 8 bits.
  - Cleared on every state entry; increments on frame_tick; saturates at 255.
- States and transitions:
  - IDLE: on i_start, clear score, lives=LIVES, o_timeout=0, go to GAP.
  - GAP: when frame_cnt==GAP_FRAMES at a frame_tick, latch o_lane from the LFSR pick and go to TRAVEL. o_active[o_lane] rises the cycle TRAVEL is entered.
  - TRAVEL:
    - The first cycle with i_in_position[o_lane]==1 goes to JUDGE. Other lanes' in_position bits are ignored.
    - Otherwise, frame_cnt==TRAVEL_TIMEOUT at a frame_tick sets o_timeout and goes to RETIRE, with no score and no hit.
  - JUDGE (exactly 1 cycle):
    - Hit when the effective player lane == o_lane && !i_player_jump.
    - Hit: o_hit pulses, lives decrement. If lives reach 0, go to OVER; otherwise go to RETIRE.
    - No hit: score+1 (saturating at all-ones), go to RETIRE.
  - RETIRE: o_active held. When frame_cnt==RETIRE_FRAMES at a frame_tick, o_active clears and state goes to GAP.
  - OVER:
    - o_active=0, o_game_over=1, counters frozen.
    - i_start goes to GAP with the same clearing as IDLE.
- o_active: at most one bit set; zero in IDLE, GAP and OVER.
- Precedence: i_start in any state other than IDLE/OVER restarts the game (clearing as IDLE) and drops o_active the next cycle.
- Simultaneous events:
  - in_position in the same cycle as the timeout frame_tick: in_position wins.
  - i_start in the same cycle as JUDGE: restart wins; no score, no hit.
- Reset mid-wave: o_active drops immediately (asynchronously).

Decomposition:
- Package barrier_pkg holds:
  - state_t enum: IDLE, GAP, TRAVEL, JUDGE, RETIRE, OVER.
  - Lane localparams LANE_L=0, LANE_M=1, LANE_R=2.
  - LFSR tap constant 8'hB8.
  - Function lane_pick(lfsr).
- Sub-module frame_tick_gen: synchronizer plus edge detect, ports i_clk, i_rst_n, i_v_sync, o_tick.

Test Plan:
- Reset then i_start; drive a v_sync period of 100 clk cycles -> o_active stays 0 for 30 ticks, then exactly one bit is set. With seed A5, the first lane matches the model LFSR output.
- Wave on lane 1, player lane 0, pulse i_in_position[1] -> no o_hit, o_score 0→1, o_active clears 8 ticks later.
- Wave on lane 1, player lane 1, jump=0 -> o_hit one cycle, o_lives 3→2. Same with jump=1 -> score+1, no hit.
- Three consecutive hits -> o_lives=0, o_game_over=1, o_active=0. i_start -> lives=3, score=0, back in GAP.
- Never assert in_position -> o_timeout set after 40 ticks in TRAVEL, o_score unchanged, o_active dropped after RETIRE_FRAMES.
- i_rst_n low while in TRAVEL -> o_active=0 within the same cycle, all outputs at reset values. i_start together with in_position -> restart, no score change.
